exu_dpath_arb: RTL and testbench

- Shares one registered adder/comparator datapath among three execute-stage requesters: ALU (id 0), BJP (id 1) and AGU (id 2).
- Replaces a private adder in each unit. BJP, for example, sends its link-address add here and gets back `pc+4` or the rs1/rs2 compare flags.
- Round-robin grant, one pipeline register on the result, valid/ready on every channel.
- Sits inside the EXU, between the decode-dispatched sub-units and the writeback mux.

---
 rtl/exu_dpath_arb_pkg.sv | 13 +
 rtl/exu_dpath_rr_pick.sv | 36 +++
 rtl/exu_dpath_arb.sv | 158 +++++++++++++++
 tb/tb_exu_dpath_arb.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/exu_dpath_arb_pkg.sv
// Shared definitions for the EXU shared adder/comparator arbiter.
// Requester id constants, id width and default sizing.
package exu_dpath_arb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREQ_DEF = 3;
  localparam int ARB_ID_W = 2;

  localparam logic [ARB_ID_W-1:0] ARB_ID_ALU = 2'd0;
  localparam logic [ARB_ID_W-1:0] ARB_ID_BJP = 2'd1;
  localparam logic [ARB_ID_W-1:0] ARB_ID_AGU = 2'd2;

endpackage

// File: rtl/exu_dpath_rr_pick.sv
// Combinational round-robin picker: searches from last_gnt+1 (wrapping)
// and returns a one-hot grant plus its encoded id. Grant is zero when no
// requester is valid. Reusable by other EXU arbiters.
module exu_dpath_rr_pick
  import exu_dpath_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = ARB_ID_W
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  last_gnt_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o
);

  // First valid requester after the previous winner, wrapping around.
  always_comb begin
    int   idx;
    logic found;
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last_gnt_i) + off) % NREQ;
      if (!found && valid_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_id_o   = IDW'(idx);
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/exu_dpath_arb.sv
// Shared registered adder/comparator for the EXU requesters (ALU, BJP, AGU).
// Round-robin grant, one result register, valid/ready on every channel.
// Optional performance counters are enabled by EXU_DPATH_ARB_PERF_EN.
module exu_dpath_arb
  import exu_dpath_arb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREQ = NREQ_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_op1,
  input  logic [NREQ*XLEN-1:0] req_op2,
  input  logic [NREQ-1:0]      req_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ARB_ID_W-1:0]  rsp_id,
  output logic [XLEN-1:0]      rsp_res,
  output logic                 rsp_eq,
  output logic                 rsp_lt,
  output logic                 rsp_ltu
`ifdef EXU_DPATH_ARB_PERF_EN
  ,
  output logic [NREQ*32-1:0]   perf_gnt_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);

  logic                rsp_valid_q, rsp_valid_d;
  logic [ARB_ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [XLEN-1:0]     rsp_res_q, rsp_res_d;
  logic                rsp_eq_q, rsp_eq_d;
  logic                rsp_lt_q, rsp_lt_d;
  logic                rsp_ltu_q, rsp_ltu_d;
  logic [ARB_ID_W-1:0] last_gnt_q, last_gnt_d;

  logic                free_s;
  logic                xfer_s;
  logic [NREQ-1:0]     gnt_s;
  logic [ARB_ID_W-1:0] gnt_id_s;
  logic [XLEN-1:0]     op1_s, op2_s, op2x_s;
  logic                sub_s;
  logic [XLEN:0]       sum_s;

  exu_dpath_rr_pick #(
    .NREQ (NREQ),
    .IDW  (ARB_ID_W)
  ) u_pick (
    .valid_i    (req_valid),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (gnt_s),
    .gnt_id_o   (gnt_id_s)
  );

  // Grant only when the result slot is empty or draining this cycle.
  always_comb begin
    free_s    = !rsp_valid_q || rsp_ready;
    req_ready = free_s ? gnt_s : '0;
    xfer_s    = |req_ready;
  end

  // Granted operands through the shared adder; flags use the raw operands.
  always_comb begin
    op1_s  = req_op1[int'(gnt_id_s)*XLEN +: XLEN];
    op2_s  = req_op2[int'(gnt_id_s)*XLEN +: XLEN];
    sub_s  = req_sub[gnt_id_s];
    op2x_s = sub_s ? ~op2_s : op2_s;
    sum_s  = {1'b0, op1_s} + {1'b0, op2x_s} + {{XLEN{1'b0}}, sub_s};
  end

  // Next state: load on transfer, drop valid on a bare drain, else hold.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_eq_d    = rsp_eq_q;
    rsp_lt_d    = rsp_lt_q;
    rsp_ltu_d   = rsp_ltu_q;
    last_gnt_d  = last_gnt_q;
    if (xfer_s) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_id_s;
      rsp_res_d   = sum_s[XLEN-1:0];
      rsp_eq_d    = (op1_s == op2_s);
      rsp_lt_d    = ($signed(op1_s) < $signed(op2_s));
      rsp_ltu_d   = (op1_s < op2_s);
      last_gnt_d  = gnt_id_s;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Result register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_res_q   <= '0;
      rsp_eq_q    <= 1'b0;
      rsp_lt_q    <= 1'b0;
      rsp_ltu_q   <= 1'b0;
      last_gnt_q  <= ARB_ID_W'(NREQ - 1);
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_eq_q    <= rsp_eq_d;
      rsp_lt_q    <= rsp_lt_d;
      rsp_ltu_q   <= rsp_ltu_d;
      last_gnt_q  <= last_gnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_eq    = rsp_eq_q;
  assign rsp_lt    = rsp_lt_q;
  assign rsp_ltu   = rsp_ltu_q;

`ifdef EXU_DPATH_ARB_PERF_EN
  logic [31:0] gnt_cnt_q [NREQ];
  logic [31:0] stall_cnt_q;

  // Per-requester grant counters and stall counter, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        gnt_cnt_q[i] <= 32'd0;
      end
      stall_cnt_q <= 32'd0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          gnt_cnt_q[i] <= gnt_cnt_q[i] + 32'd1;
        end else begin
          gnt_cnt_q[i] <= gnt_cnt_q[i];
        end
      end
      if ((|req_valid) && !free_s) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_perf
    assign perf_gnt_cnt[g*32 +: 32] = gnt_cnt_q[g];
  end
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_exu_dpath_arb.sv
// Self-checking bench for exu_dpath_arb: a table of single-request vectors
// followed by hand-written fairness, back-pressure and reset sequences.
// Define EXU_DPATH_ARB_PERF_EN to also check the performance counters.
module tb_exu_dpath_arb;

  localparam int XLEN = 32;
  localparam int NREQ = 3;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_op1;
  logic [NREQ*XLEN-1:0] req_op2;
  logic [NREQ-1:0]      req_sub;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_id;
  logic [XLEN-1:0]      rsp_res;
  logic                 rsp_eq, rsp_lt, rsp_ltu;
`ifdef EXU_DPATH_ARB_PERF_EN
  logic [NREQ*32-1:0]   perf_gnt_cnt;
  logic [31:0]          perf_stall_cnt;
`endif

  int n_tests;
  int n_fail;

  exu_dpath_arb #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_res   (rsp_res),
    .rsp_eq    (rsp_eq),
    .rsp_lt    (rsp_lt),
    .rsp_ltu   (rsp_ltu)
`ifdef EXU_DPATH_ARB_PERF_EN
    ,
    .perf_gnt_cnt   (perf_gnt_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        sub;
    logic [31:0] res;
    logic        eq;
    logic        lt;
    logic        ltu;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    req_valid = '0;
    req_op1   = '0;
    req_op2   = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b1;

    //            id  op1           op2           sub   res           eq    lt    ltu
    vecs[0] = '{1, 32'h8000_0000, 32'h0000_0004, 1'b0, 32'h8000_0004, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{2, 32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1, 32'h0000_000A, 32'h0000_0003, 1'b1, 32'h0000_0007, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{0, 32'h0000_0003, 32'h0000_000A, 1'b1, 32'hFFFF_FFF9, 1'b0, 1'b1, 1'b1};

    // Reset state
    do_reset();
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id",    32'(rsp_id),    32'd0);
    chk("rst_res",   rsp_res,        32'd0);
    chk("rst_flags", 32'({rsp_eq, rsp_lt, rsp_ltu}), 32'd0);

    // Table of single-requester operations, one-cycle latency each
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      req_valid = '0;
      req_op1   = '0;
      req_op2   = '0;
      req_sub   = '0;
      req_valid[vecs[v].id] = 1'b1;
      req_op1[vecs[v].id*XLEN +: XLEN] = vecs[v].op1;
      req_op2[vecs[v].id*XLEN +: XLEN] = vecs[v].op2;
      req_sub[vecs[v].id] = vecs[v].sub;
      rsp_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_ready", v), 32'(req_ready), 32'(1) << vecs[v].id);
      @(negedge clk);
      req_valid = '0;
      #1;
      chk($sformatf("v%0d_valid", v), 32'(rsp_valid), 32'd1);
      chk($sformatf("v%0d_id", v),    32'(rsp_id),    32'(vecs[v].id));
      chk($sformatf("v%0d_res", v),   rsp_res,        vecs[v].res);
      chk($sformatf("v%0d_eq", v),    32'(rsp_eq),    32'(vecs[v].eq));
      chk($sformatf("v%0d_lt", v),    32'(rsp_lt),    32'(vecs[v].lt));
      chk($sformatf("v%0d_ltu", v),   32'(rsp_ltu),   32'(vecs[v].ltu));
    end
    @(negedge clk);
    #1;
    chk("drain_valid", 32'(rsp_valid), 32'd0);

    // Round-robin fairness: all valid, consumer always ready
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_op1[i*XLEN +: XLEN] = 32'(100 + i);
      req_op2[i*XLEN +: XLEN] = 32'(i);
    end
    req_sub   = '0;
    req_valid = 3'b111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(1) << (k % 3));
      if (k > 0) begin
        chk($sformatf("rr%0d_valid", k), 32'(rsp_valid), 32'd1);
        chk($sformatf("rr%0d_id", k),    32'(rsp_id),    32'((k - 1) % 3));
        chk($sformatf("rr%0d_res", k),   rsp_res,        32'(100 + 2 * ((k - 1) % 3)));
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
`ifdef EXU_DPATH_ARB_PERF_EN
    #1;
    chk("perf_gnt0", perf_gnt_cnt[31:0],  32'd2);
    chk("perf_gnt1", perf_gnt_cnt[63:32], 32'd2);
    chk("perf_gnt2", perf_gnt_cnt[95:64], 32'd2);
`endif

    // Back-pressure: result from requester 2 held, all requesters stalled
    for (int j = 0; j < 3; j++) begin
      #1;
      chk($sformatf("bp%0d_ready", j), 32'(req_ready), 32'd0);
      chk($sformatf("bp%0d_valid", j), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d_id", j),    32'(rsp_id),    32'd2);
      chk($sformatf("bp%0d_res", j),   rsp_res,        32'd104);
      @(negedge clk);
    end
`ifdef EXU_DPATH_ARB_PERF_EN
    #1;
    chk("perf_stall", perf_stall_cnt, 32'd3);
`endif
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b001);
    @(negedge clk);
    #1;
    chk("bp_release_id",  32'(rsp_id),  32'd0);
    chk("bp_release_res", rsp_res,      32'd100);

    // Mid-stall reset: result discarded asynchronously, ALU wins first after
    rsp_ready = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'b001);
    @(negedge clk);
    #1;
    chk("post_rst_valid", 32'(rsp_valid), 32'd1);
    chk("post_rst_id",    32'(rsp_id),    32'd0);
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
